// File: rtl/frame_write_sequencer_pkg.sv
// Shared types and frame-format constants for the frame write sequencer.
package frame_write_sequencer_pkg;

    // Default geometry of the configuration fabric and the frame word format.
    localparam int DefNumberOfRows     = 4;
    localparam int DefNumberOfCols     = 5;
    localparam int DefFrameBitsPerRow  = 32;
    localparam int DefMaxFramesPerCol  = 20;
    localparam int DefFrameSelectWidth = 5;
    localparam int DefRowSelectWidth   = 5;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // The column field occupies the top FrameSelectWidth bits of the address word.
    function automatic int column_lsb(input int frame_bits, input int select_width);
        return frame_bits - select_width;
    endfunction

endpackage

// File: rtl/frame_addr_check.sv
// Combinational address-word validation: column in range and exactly one frame bit set.
module frame_addr_check #(
    parameter int NumberOfCols     = 5,
    parameter int FrameSelectWidth = 5,
    parameter int MaxFramesPerCol  = 20
) (
    input  logic [FrameSelectWidth-1:0] column,
    input  logic [MaxFramesPerCol-1:0]  frame_strobe,
    output logic                        addr_valid
);

    localparam logic [MaxFramesPerCol-1:0] StrobeOne = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

    logic [31:0] column_ext_s;
    logic        column_ok_s;
    logic        one_hot_s;

    // Column range test and one-hot test of the frame strobe field.
    always_comb begin
        column_ext_s = 32'(column);
        column_ok_s  = (column_ext_s < 32'(NumberOfCols));
        one_hot_s    = (frame_strobe != '0) &&
                       ((frame_strobe & (frame_strobe - StrobeOne)) == '0);
        addr_valid   = column_ok_s && one_hot_s;
    end

endmodule

// File: rtl/frame_write_sequencer.sv
// Accepts an address word followed by one data word per fabric row, writes the rows
// one by one and then pulses LongFrameStrobe to commit the frame.
module frame_write_sequencer
    import frame_write_sequencer_pkg::*;
#(
    parameter int NumberOfRows     = DefNumberOfRows,
    parameter int NumberOfCols     = DefNumberOfCols,
    parameter int FrameBitsPerRow  = DefFrameBitsPerRow,
    parameter int MaxFramesPerCol  = DefMaxFramesPerCol,
    parameter int FrameSelectWidth = DefFrameSelectWidth,
    parameter int RowSelectWidth   = DefRowSelectWidth
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       s_valid,
    input  logic [FrameBitsPerRow-1:0] s_data,
    output logic                       s_ready,
    output logic [FrameBitsPerRow-1:0] FrameAddressRegister,
    output logic [RowSelectWidth-1:0]  RowSelect,
    output logic [FrameBitsPerRow-1:0] ConfigWriteData,
    output logic                       ConfigWriteStrobe,
    output logic                       LongFrameStrobe,
    output logic                       busy,
    output logic                       error,
    output logic [15:0]                frame_count
);

    localparam int                      ColLsb  = column_lsb(FrameBitsPerRow, FrameSelectWidth);
    localparam logic [RowSelectWidth-1:0] LastRow = RowSelectWidth'(NumberOfRows);
    localparam logic [RowSelectWidth-1:0] RowOne  = {{(RowSelectWidth-1){1'b0}}, 1'b1};

    state_t                      state_r;
    logic [RowSelectWidth-1:0]   row_cnt_r;
    logic [FrameBitsPerRow-1:0]  addr_r;
    logic [RowSelectWidth-1:0]   row_sel_r;
    logic [FrameBitsPerRow-1:0]  wr_data_r;
    logic                        wr_strobe_r;
    logic                        commit_r;
    logic                        error_r;
    logic [15:0]                 frame_count_r;
    logic                        addr_valid_s;
    logic                        accept_s;

    frame_addr_check #(
        .NumberOfCols     (NumberOfCols),
        .FrameSelectWidth (FrameSelectWidth),
        .MaxFramesPerCol  (MaxFramesPerCol)
    ) u_addr_check (
        .column       (s_data[ColLsb +: FrameSelectWidth]),
        .frame_strobe (s_data[MaxFramesPerCol-1:0]),
        .addr_valid   (addr_valid_s)
    );

    // A word is never taken during the commit cycle or while an abort is requested.
    assign s_ready  = (state_r != ST_COMMIT) && !clear;
    assign busy     = (state_r != ST_IDLE);
    assign accept_s = s_valid && s_ready;

    assign FrameAddressRegister = addr_r;
    assign RowSelect            = row_sel_r;
    assign ConfigWriteData      = wr_data_r;
    assign ConfigWriteStrobe    = wr_strobe_r;
    assign LongFrameStrobe      = commit_r;
    assign error                = error_r;
    assign frame_count          = frame_count_r;

    // Frame sequencing FSM with registered row writes, commit pulse and status.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            row_cnt_r     <= '0;
            addr_r        <= '0;
            row_sel_r     <= '0;
            wr_data_r     <= '0;
            wr_strobe_r   <= 1'b0;
            commit_r      <= 1'b0;
            error_r       <= 1'b0;
            frame_count_r <= 16'd0;
        end else if (clear) begin
            // Abort: address register, last data word and frame count are kept.
            state_r     <= ST_IDLE;
            row_cnt_r   <= '0;
            row_sel_r   <= '0;
            wr_strobe_r <= 1'b0;
            commit_r    <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            row_sel_r   <= '0;
            wr_strobe_r <= 1'b0;
            commit_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        row_cnt_r <= RowOne;
                        if (addr_valid_s) begin
                            addr_r  <= s_data;
                            state_r <= ST_DATA;
                        end else begin
                            error_r <= 1'b1;
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        wr_data_r   <= s_data;
                        wr_strobe_r <= 1'b1;
                        row_sel_r   <= row_cnt_r;
                        if (row_cnt_r == LastRow) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            row_cnt_r <= row_cnt_r + RowOne;
                        end
                    end
                end
                ST_COMMIT: begin
                    commit_r      <= 1'b1;
                    frame_count_r <= frame_count_r + 16'd1;
                    state_r       <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (accept_s) begin
                        if (row_cnt_r == LastRow) begin
                            state_r <= ST_IDLE;
                        end else begin
                            row_cnt_r <= row_cnt_r + RowOne;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Directed self-checking bench for frame_write_sequencer at default parameters.
module tb_frame_write_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        clear;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [31:0] FrameAddressRegister;
    logic [4:0]  RowSelect;
    logic [31:0] ConfigWriteData;
    logic        ConfigWriteStrobe;
    logic        LongFrameStrobe;
    logic        busy;
    logic        error;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;

    frame_write_sequencer dut (
        .CLK                  (CLK),
        .reset                (reset),
        .clear                (clear),
        .s_valid              (s_valid),
        .s_data               (s_data),
        .s_ready              (s_ready),
        .FrameAddressRegister (FrameAddressRegister),
        .RowSelect            (RowSelect),
        .ConfigWriteData      (ConfigWriteData),
        .ConfigWriteStrobe    (ConfigWriteStrobe),
        .LongFrameStrobe      (LongFrameStrobe),
        .busy                 (busy),
        .error                (error),
        .frame_count          (frame_count)
    );

    always #5 CLK = ~CLK;

    // Present one word for one clock; acc reports whether it was taken.
    task automatic drive_word(input logic [31:0] w, output logic acc);
        s_valid = 1'b1;
        s_data  = w;
        acc     = s_ready;
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle_cycle;
        s_valid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        total++; if ({FrameAddressRegister, ConfigWriteData} !== 64'd0) begin bad++; $display("FAIL reset_regs: got %h %h want 0", FrameAddressRegister, ConfigWriteData); end
        total++; if ({RowSelect, ConfigWriteStrobe, LongFrameStrobe, error} !== 8'd0) begin bad++; $display("FAIL reset_ctrl: got %b want 0", {RowSelect, ConfigWriteStrobe, LongFrameStrobe, error}); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    endtask

    task automatic test_single_frame;
        logic acc;
        drive_word(32'h0000_0004, acc);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_addr_acc: got %b want 1", acc); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        total++; if (FrameAddressRegister !== 32'h0000_0004) begin bad++; $display("FAIL single_far: got %h want 00000004", FrameAddressRegister); end
        total++; if (ConfigWriteStrobe !== 1'b0) begin bad++; $display("FAIL single_nostrobe: got %b want 0", ConfigWriteStrobe); end
        for (int i = 0; i < 4; i++) begin
            drive_word(32'hA1 + 32'(i), acc);
            total++; if (ConfigWriteStrobe !== 1'b1) begin bad++; $display("FAIL single_cws%0d: got %b want 1", i + 1, ConfigWriteStrobe); end
            total++; if (RowSelect !== 5'(i + 1)) begin bad++; $display("FAIL single_row%0d: got %0d want %0d", i + 1, RowSelect, i + 1); end
            total++; if (ConfigWriteData !== 32'hA1 + 32'(i)) begin bad++; $display("FAIL single_data%0d: got %h want %h", i + 1, ConfigWriteData, 32'hA1 + 32'(i)); end
            total++; if (LongFrameStrobe !== 1'b0) begin bad++; $display("FAIL single_early_lfs%0d: got %b want 0", i + 1, LongFrameStrobe); end
        end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL single_commit_ready: got %b want 0", s_ready); end
        idle_cycle();
        total++; if (LongFrameStrobe !== 1'b1) begin bad++; $display("FAIL single_lfs: got %b want 1", LongFrameStrobe); end
        total++; if ({RowSelect, ConfigWriteStrobe} !== 6'd0) begin bad++; $display("FAIL single_commit_quiet: got %b want 0", {RowSelect, ConfigWriteStrobe}); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", frame_count); end
        total++; if (FrameAddressRegister !== 32'h0000_0004) begin bad++; $display("FAIL single_far_hold: got %h want 00000004", FrameAddressRegister); end
        idle_cycle();
        total++; if ({LongFrameStrobe, busy} !== 2'b00) begin bad++; $display("FAIL single_after: got %b want 00", {LongFrameStrobe, busy}); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [15];
        int          idx;
        int          lfs_n;
        int          cws_n;
        int          overlap;
        int          lfs_at [3];
        logic        acc;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            words[f * 5] = 32'h1 << f;
            for (int r = 1; r <= 4; r++) words[f * 5 + r] = 32'h100 * 32'(f) + 32'(r);
        end
        idx = 0; lfs_n = 0; cws_n = 0; overlap = 0;
        for (int k = 0; k < 3; k++) lfs_at[k] = 0;
        for (int c = 1; c <= 24; c++) begin
            s_valid = (idx < 15);
            s_data  = (idx < 15) ? words[idx] : 32'd0;
            acc     = s_valid && s_ready;
            @(posedge CLK);
            #1;
            if (acc) idx++;
            if (ConfigWriteStrobe) cws_n++;
            if (LongFrameStrobe && ConfigWriteStrobe) overlap++;
            if (LongFrameStrobe) begin
                if (lfs_n < 3) lfs_at[lfs_n] = c;
                lfs_n++;
            end
        end
        s_valid = 1'b0;
        total++; if (lfs_n !== 3) begin bad++; $display("FAIL b2b_lfs_count: got %0d want 3", lfs_n); end
        for (int k = 0; k < 3; k++) begin
            total++; if (lfs_at[k] !== 6 * (k + 1)) begin bad++; $display("FAIL b2b_lfs_cycle%0d: got %0d want %0d", k, lfs_at[k], 6 * (k + 1)); end
        end
        total++; if (cws_n !== 12) begin bad++; $display("FAIL b2b_cws_count: got %0d want 12", cws_n); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
        total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL b2b_count: got %0d want 3", frame_count); end
        total++; if (FrameAddressRegister !== 32'h0000_0004) begin bad++; $display("FAIL b2b_far: got %h want 00000004", FrameAddressRegister); end
    endtask

    task automatic test_bad_column;
        logic acc;
        drive_word(32'h2800_0001, acc);
        total++; if ({error, busy} !== 2'b11) begin bad++; $display("FAIL badcol_err: got %b want 11", {error, busy}); end
        total++; if (FrameAddressRegister !== 32'h0000_0004) begin bad++; $display("FAIL badcol_far: got %h want 00000004", FrameAddressRegister); end
        for (int i = 0; i < 4; i++) begin
            drive_word(32'hDEAD_0000 + 32'(i), acc);
            total++; if ({ConfigWriteStrobe, LongFrameStrobe} !== 2'b00) begin bad++; $display("FAIL badcol_strobe%0d: got %b want 00", i, {ConfigWriteStrobe, LongFrameStrobe}); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL badcol_idle: got %b want 0", busy); end
        idle_cycle();
        total++; if ({LongFrameStrobe, FrameAddressRegister} !== {1'b0, 32'h0000_0004}) begin bad++; $display("FAIL badcol_after: got %b %h want 0 00000004", LongFrameStrobe, FrameAddressRegister); end
        drive_word(32'h0800_0010, acc);
        for (int i = 0; i < 4; i++) drive_word(32'hB0 + 32'(i), acc);
        idle_cycle();
        total++; if (LongFrameStrobe !== 1'b1) begin bad++; $display("FAIL badcol_next_lfs: got %b want 1", LongFrameStrobe); end
        total++; if (frame_count !== 16'd4) begin bad++; $display("FAIL badcol_next_count: got %0d want 4", frame_count); end
        total++; if (FrameAddressRegister !== 32'h0800_0010) begin bad++; $display("FAIL badcol_next_far: got %h want 08000010", FrameAddressRegister); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL badcol_sticky: got %b want 1", error); end
        idle_cycle();
    endtask

    task automatic test_bad_strobe;
        logic acc;
        clear = 1'b1;
        idle_cycle();
        clear = 1'b0;
        total++; if (error !== 1'b0) begin bad++; $display("FAIL badstb_pre_clear: got %b want 0", error); end
        drive_word(32'h0000_0003, acc);
        total++; if ({error, busy} !== 2'b11) begin bad++; $display("FAIL badstb_err: got %b want 11", {error, busy}); end
        s_valid = 1'b1;
        s_data  = 32'h0000_0004;
        clear   = 1'b1;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL badstb_clear_ready: got %b want 0", s_ready); end
        @(posedge CLK);
        #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        total++; if ({error, busy} !== 2'b00) begin bad++; $display("FAIL badstb_cleared: got %b want 00", {error, busy}); end
        total++; if (FrameAddressRegister !== 32'h0800_0010) begin bad++; $display("FAIL badstb_far: got %h want 08000010", FrameAddressRegister); end
        drive_word(32'h0000_0004, acc);
        total++; if ({busy, FrameAddressRegister} !== {1'b1, 32'h0000_0004}) begin bad++; $display("FAIL badstb_readdr: got %b %h want 1 00000004", busy, FrameAddressRegister); end
        for (int i = 0; i < 4; i++) drive_word(32'hC0 + 32'(i), acc);
        idle_cycle();
        total++; if (frame_count !== 16'd5) begin bad++; $display("FAIL badstb_count: got %0d want 5", frame_count); end
        idle_cycle();
    endtask

    task automatic test_clear_commit;
        logic acc;
        drive_word(32'h0000_0008, acc);
        for (int i = 0; i < 4; i++) drive_word(32'hD0 + 32'(i), acc);
        clear = 1'b1;
        idle_cycle();
        clear = 1'b0;
        total++; if ({LongFrameStrobe, busy} !== 2'b00) begin bad++; $display("FAIL clrcmt_lfs: got %b want 00", {LongFrameStrobe, busy}); end
        total++; if (frame_count !== 16'd5) begin bad++; $display("FAIL clrcmt_count: got %0d want 5", frame_count); end
        total++; if (FrameAddressRegister !== 32'h0000_0008) begin bad++; $display("FAIL clrcmt_far: got %h want 00000008", FrameAddressRegister); end
        idle_cycle();
        total++; if (LongFrameStrobe !== 1'b0) begin bad++; $display("FAIL clrcmt_late_lfs: got %b want 0", LongFrameStrobe); end
    endtask

    task automatic test_stall;
        logic acc;
        int   lfs_edge;
        lfs_edge = 0;
        drive_word(32'h0000_0020, acc);
        drive_word(32'hE1, acc);
        drive_word(32'hE2, acc);
        for (int g = 0; g < 3; g++) begin
            idle_cycle();
            total++; if ({ConfigWriteStrobe, LongFrameStrobe, RowSelect} !== 7'd0) begin bad++; $display("FAIL stall_gap%0d: got %b want 0", g, {ConfigWriteStrobe, LongFrameStrobe, RowSelect}); end
        end
        drive_word(32'hE3, acc);
        total++; if ({RowSelect, ConfigWriteData} !== {5'd3, 32'hE3}) begin bad++; $display("FAIL stall_row3: got %0d %h want 3 e3", RowSelect, ConfigWriteData); end
        drive_word(32'hE4, acc);
        total++; if ({RowSelect, ConfigWriteData} !== {5'd4, 32'hE4}) begin bad++; $display("FAIL stall_row4: got %0d %h want 4 e4", RowSelect, ConfigWriteData); end
        for (int k = 9; k <= 12; k++) begin
            idle_cycle();
            if (LongFrameStrobe && lfs_edge == 0) lfs_edge = k;
        end
        total++; if (lfs_edge !== 9) begin bad++; $display("FAIL stall_lfs_edge: got %0d want 9", lfs_edge); end
        total++; if (frame_count !== 16'd6) begin bad++; $display("FAIL stall_count: got %0d want 6", frame_count); end
    endtask

    task automatic test_reset_mid;
        logic acc;
        int   lfs_seen;
        lfs_seen = 0;
        drive_word(32'h0000_0040, acc);
        for (int i = 0; i < 3; i++) drive_word(32'hF1 + 32'(i), acc);
        reset = 1'b1;
        #1;
        total++; if ({FrameAddressRegister, ConfigWriteData} !== 64'd0) begin bad++; $display("FAIL rstmid_regs: got %h %h want 0", FrameAddressRegister, ConfigWriteData); end
        total++; if ({RowSelect, ConfigWriteStrobe, LongFrameStrobe, error, busy} !== 9'd0) begin bad++; $display("FAIL rstmid_ctrl: got %b want 0", {RowSelect, ConfigWriteStrobe, LongFrameStrobe, error, busy}); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", frame_count); end
        @(posedge CLK);
        #1;
        reset = 1'b0;
        idle_cycle();
        total++; if ({s_ready, busy} !== 2'b10) begin bad++; $display("FAIL rstmid_release: got %b want 10", {s_ready, busy}); end
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            if (LongFrameStrobe || ConfigWriteStrobe) lfs_seen++;
        end
        total++; if (lfs_seen !== 0) begin bad++; $display("FAIL rstmid_ghost: got %0d want 0", lfs_seen); end
        drive_word(32'h0000_0080, acc);
        for (int i = 0; i < 4; i++) drive_word(32'h11 + 32'(i), acc);
        idle_cycle();
        total++; if ({LongFrameStrobe, frame_count} !== {1'b1, 16'd1}) begin bad++; $display("FAIL rstmid_next: got %b %0d want 1 1", LongFrameStrobe, frame_count); end
    endtask

    initial begin
        reset   = 1'b1;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'd0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bad_column();
        test_bad_strobe();
        test_clear_commit();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
